// File: rtl/inst_loader.sv
// Byte-serial program loader: assembles 16-bit instructions from a framed byte
// stream, buffers them in a small FIFO and writes them to instruction memory.
module inst_loader #(
    parameter int         ISA_WIDTH  = 16,
    parameter int         FIFO_DEPTH = 4,
    parameter logic [7:0] SYNC_BYTE  = 8'hA5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 inst_ready,
    output logic                 inst_wen,
    output logic [ISA_WIDTH-1:0] input_inst,
    output logic                 busy,
    output logic                 load_done,
    output logic [7:0]           err_cnt
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_COUNT = 3'd1;
    localparam logic [2:0] ST_LO    = 3'd2;
    localparam logic [2:0] ST_HI    = 3'd3;
    localparam logic [2:0] ST_DRAIN = 3'd4;

    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(FIFO_DEPTH);

    logic [2:0]           state_r;
    logic [2:0]           state_nxt_s;
    logic [8:0]           remain_r;
    logic [7:0]           lo_byte_r;
    logic [ISA_WIDTH-1:0] fifo_mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_r;
    logic [PTR_W-1:0]     rd_ptr_r;
    logic [PTR_W:0]       count_r;
    logic                 inst_wen_r;
    logic [ISA_WIDTH-1:0] input_inst_r;
    logic                 load_done_r;
    logic [7:0]           err_cnt_r;

    logic fifo_full_s;
    logic fifo_empty_s;
    logic accept_s;
    logic push_s;
    logic pop_s;
    logic in_ready_s;

    assign fifo_full_s  = (count_r == CNT_FULL);
    assign fifo_empty_s = (count_r == {(PTR_W + 1){1'b0}});
    assign accept_s     = in_valid && in_ready_s;
    assign push_s       = accept_s && (state_r == ST_HI);
    assign pop_s        = !fifo_empty_s && inst_ready;

    assign in_ready   = in_ready_s;
    assign busy       = (state_r != ST_IDLE);
    assign inst_wen   = inst_wen_r;
    assign input_inst = input_inst_r;
    assign load_done  = load_done_r;
    assign err_cnt    = err_cnt_r;

    // Byte acceptance depends only on state and FIFO room
    always_comb begin
        in_ready_s = 1'b0;
        case (state_r)
            ST_IDLE:  in_ready_s = 1'b1;
            ST_COUNT: in_ready_s = 1'b1;
            ST_LO:    in_ready_s = 1'b1;
            ST_HI:    in_ready_s = !fifo_full_s;
            ST_DRAIN: in_ready_s = 1'b0;
            default:  in_ready_s = 1'b0;
        endcase
    end

    // Frame sequencing
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s && (in_data == SYNC_BYTE)) state_nxt_s = ST_COUNT;
                else                                    state_nxt_s = ST_IDLE;
            end
            ST_COUNT: begin
                if (accept_s) state_nxt_s = ST_LO;
                else          state_nxt_s = ST_COUNT;
            end
            ST_LO: begin
                if (accept_s) state_nxt_s = ST_HI;
                else          state_nxt_s = ST_LO;
            end
            ST_HI: begin
                if (push_s && (remain_r == 9'd1)) state_nxt_s = ST_DRAIN;
                else if (push_s)                  state_nxt_s = ST_LO;
                else                              state_nxt_s = ST_HI;
            end
            ST_DRAIN: begin
                // Empty FIFO here means the final write is on the bus this cycle
                if (fifo_empty_s) state_nxt_s = ST_IDLE;
                else              state_nxt_s = ST_DRAIN;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State, frame counters and error counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            remain_r    <= 9'd0;
            lo_byte_r   <= 8'd0;
            err_cnt_r   <= 8'd0;
            load_done_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            load_done_r <= (state_r == ST_DRAIN) && fifo_empty_s;
            if ((state_r == ST_IDLE) && accept_s && (in_data != SYNC_BYTE) &&
                (err_cnt_r != 8'hFF)) begin
                err_cnt_r <= err_cnt_r + 8'd1;
            end
            if ((state_r == ST_COUNT) && accept_s) begin
                remain_r <= (in_data == 8'd0) ? 9'd256 : {1'b0, in_data};
            end else if (push_s) begin
                remain_r <= remain_r - 9'd1;
            end
            if ((state_r == ST_LO) && accept_s) begin
                lo_byte_r <= in_data;
            end
        end
    end

    // FIFO pointers, occupancy and the registered write port
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r     <= {PTR_W{1'b0}};
            rd_ptr_r     <= {PTR_W{1'b0}};
            count_r      <= {(PTR_W + 1){1'b0}};
            inst_wen_r   <= 1'b0;
            input_inst_r <= {ISA_WIDTH{1'b0}};
        end else begin
            if (push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
            if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
            inst_wen_r <= pop_s;
            if (pop_s) input_inst_r <= fifo_mem_r[rd_ptr_r];
        end
    end

    // FIFO storage needs no reset; occupancy guards every read
    always_ff @(posedge clk) begin
        if (push_s) fifo_mem_r[wr_ptr_r] <= {in_data, lo_byte_r};
    end

endmodule

// File: doc/inst_loader.md
# inst_loader

Program loader that sits directly upstream of the core's instruction memory. It receives a byte-serial program frame over a valid/ready handshake and assembles 16-bit instructions. It buffers them in a small FIFO and writes them into the core one per cycle on `inst_wen`/`input_inst`. `busy` holds the rest of the system off while a frame is being loaded.

## Interface
- `ISA_WIDTH`, 16, instruction width; fixed at 16 (two bytes per instruction).
- `FIFO_DEPTH`, 4, instruction FIFO entries; power of two, ≥2.
- `SYNC_BYTE`, 8'hA5, frame start marker.

- `clk`  in  1  single clock, all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_data`  in  8  host byte.
- `in_valid`  in  1  `in_data` valid.
- `in_ready`  out  1  loader accepts byte this cycle.
- `inst_ready`  in  1  downstream can take a write this cycle; tied 1 when unused.
- `inst_wen`  out  1  instruction write enable to instruction memory.
- `input_inst`  out  16  instruction word to instruction memory.
- `busy`  out  1  frame in progress (state ≠ IDLE).
- `load_done`  out  1  one-cycle pulse, frame fully written.
- `err_cnt`  out  8  saturating count of bytes discarded in IDLE.

## Operation
- Frame format: `SYNC_BYTE`, count byte N, then N instructions. Each instruction is low byte first, then high byte. N=0 means 256.
- A byte is accepted on a rising edge where `in_valid && in_ready`.
- FSM states and transitions:
  - IDLE: `in_ready`=1. Accepted byte == `SYNC_BYTE` → COUNT. Any other accepted byte is dropped; `err_cnt`+1, saturating at 255.
  - COUNT: `in_ready`=1. Latch N into a 9-bit remaining counter (0 → 256) → LO.
  - LO: `in_ready`=1. Latch low byte → HI.
  - HI: `in_ready` = FIFO not full.
    - On accept, push {in_data, low_byte} and decrement remaining.
    - Remaining becomes 0 → DRAIN; otherwise → LO.
  - DRAIN: `in_ready`=0. Wait until the FIFO is empty and no write is pending → IDLE, pulsing `load_done`.
- Output side, every edge:
  - If FIFO non-empty and `inst_ready`: pop, register `inst_wen`=1 and `input_inst`=word.
  - Otherwise register `inst_wen`=0; `input_inst` holds its last value.
- Push and pop in the same edge are legal; occupancy is unchanged. No push occurs while full. Pop and write pointers wrap modulo `FIFO_DEPTH`.
- Words leave in arrival order; no word is lost or duplicated.
- `err_cnt` counts only in IDLE. It is never cleared except by `rst`.

## Timing
- Reset values: state IDLE, FIFO empty, `inst_wen`=0, `input_inst`=0, `load_done`=0, `busy`=0, `err_cnt`=0. In the first cycle after reset, `in_ready`=1.
- `in_ready` and `busy` are combinational from state and FIFO occupancy. `inst_wen`, `input_inst`, `load_done` and `err_cnt` are registered.
- Latency, with `inst_ready`=1 and FIFO previously empty:
  - HI byte accepted at edge k → word in FIFO after edge k.
  - Popped at edge k+1 → `inst_wen`=1 during the cycle after edge k+1.
- Throughput: one instruction per two accepted bytes; the output drains ≥ input rate when `inst_ready`=1.
- `load_done` is high exactly one cycle: the cycle after the last `inst_wen` cycle of the frame.
- `busy` goes 1 the cycle after the sync byte is accepted. It goes 0 in the same cycle `load_done` is high.
- Bytes presented during DRAIN are not accepted; the host holds them.
- `rst` mid-frame: the next cycle is in IDLE, FIFO flushed, `inst_wen`=0, partial word discarded, no `load_done`.
- `inst_ready`=0 for an extended time: FIFO fills, `in_ready` drops in HI, and loading resumes without loss.

## Test plan
- Basic frame: bytes A5,02,34,12,CD,AB with `in_valid` continuous, `inst_ready`=1 → `inst_wen` pulses carry 1234 then ABCD. `load_done` pulses once, the cycle after the ABCD write; `busy` then 0.
- Garbage before sync: bytes 00,FF,A5,01,01,00 → `err_cnt`=2, one write of 0001, `load_done` once.
- Backpressure: frame of N=6 with `inst_ready`=0 → after 4 words `in_ready`=0 in HI. Then raise `inst_ready` → six writes in order, none lost, `load_done` after the sixth.
- N=0 frame with 256 incrementing words 0000..00FF → exactly 256 writes, in order, then `load_done`.
- Reset mid-frame: assert `rst` after A5,03,11 → next cycle shows `busy`=0, `inst_wen`=0, FIFO empty. A following frame A5,01,22,11 writes only 1122.
- `err_cnt` saturation: 300 non-sync bytes in IDLE → `err_cnt`=255, with no writes and no `load_done`.
